// File: rtl/dec_bypass_ring.sv
// Registered bypass ring between deflection subrouters, with per-subnet drain FIFOs.
// Optional drain/saturation statistics are enabled by defining BYPASS_STAT_EN.
`ifndef WIDTH_PORT
`define WIDTH_PORT 32
`endif
`ifndef WIDTH_PV
`define WIDTH_PV 4
`endif

module dec_bypass_ring #(
  parameter int NUM_SUBNET = 2,
  parameter int WIDTH_PORT = `WIDTH_PORT,
  parameter int WIDTH_PV   = `WIDTH_PV,
  parameter int MAX_HOP    = 3,
  parameter int HOP_W      = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SUBNET*WIDTH_PORT-1:0] byp_in,
  input  logic [NUM_SUBNET*WIDTH_PV-1:0]   pv_in,
  input  logic [NUM_SUBNET-1:0]            vld_in,
  input  logic [NUM_SUBNET-1:0]            fwd_in,
  output logic [NUM_SUBNET*WIDTH_PORT-1:0] byp_out,
  output logic [NUM_SUBNET*WIDTH_PV-1:0]   pv_out,
  output logic [NUM_SUBNET-1:0]            vld_out,
  output logic [NUM_SUBNET*WIDTH_PORT-1:0] drain_flit,
  output logic [NUM_SUBNET-1:0]            drain_vld,
  input  logic [NUM_SUBNET-1:0]            drain_rdy,
  output logic [NUM_SUBNET*16-1:0]         stat_drain,
  output logic [NUM_SUBNET*16-1:0]         stat_sat
);

  localparam logic [HOP_W-1:0] MAXH = HOP_W'(MAX_HOP);

  logic [WIDTH_PORT-1:0] r_flit [NUM_SUBNET];
  logic [WIDTH_PV-1:0]   r_pv   [NUM_SUBNET];
  logic [NUM_SUBNET-1:0] r_vld;
  logic [HOP_W-1:0]      r_hop  [NUM_SUBNET];
  logic [HOP_W-1:0]      hop_nxt[NUM_SUBNET];

  logic [WIDTH_PORT-1:0] mem    [NUM_SUBNET][2];
  logic [NUM_SUBNET-1:0] wr_ptr, rd_ptr;
  logic [1:0]            cnt    [NUM_SUBNET];

  logic [NUM_SUBNET-1:0] arr_max, push, pop;

  // Stage feeding subnet j is the one loaded by subnet j-1.
  function automatic int src(input int j);
    return (j + NUM_SUBNET - 1) % NUM_SUBNET;
  endfunction

  always_comb begin
    arr_max    = '0;
    push       = '0;
    pop        = '0;
    vld_out    = '0;
    byp_out    = '0;
    pv_out     = '0;
    drain_vld  = '0;
    drain_flit = '0;
    for (int j = 0; j < NUM_SUBNET; j++) begin
      hop_nxt[j] = '0;
      arr_max[j] = r_vld[src(j)] && (r_hop[src(j)] == MAXH);
      pop[j]     = drain_rdy[j] && (cnt[j] != 2'd0);
      // A full FIFO still accepts when it is popped in the same cycle.
      push[j]    = arr_max[j] && ((cnt[j] != 2'd2) || pop[j]);
      vld_out[j] = !reset && r_vld[src(j)] && !push[j];
      if (vld_out[j]) begin
        byp_out[j*WIDTH_PORT +: WIDTH_PORT] = r_flit[src(j)];
        pv_out[j*WIDTH_PV +: WIDTH_PV]      = r_pv[src(j)];
      end
      drain_vld[j] = !reset && (cnt[j] != 2'd0);
      if (drain_vld[j])
        drain_flit[j*WIDTH_PORT +: WIDTH_PORT] = mem[j][rd_ptr[j]];
      if (fwd_in[j])
        hop_nxt[j] = (r_hop[src(j)] == MAXH) ? MAXH : r_hop[src(j)] + HOP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SUBNET; i++) begin
      if (reset) begin
        r_vld[i]  <= 1'b0;
        r_hop[i]  <= '0;
        cnt[i]    <= 2'd0;
        wr_ptr[i] <= 1'b0;
        rd_ptr[i] <= 1'b0;
      end else begin
        r_vld[i]  <= vld_in[i];
        r_hop[i]  <= hop_nxt[i];
        r_flit[i] <= byp_in[i*WIDTH_PORT +: WIDTH_PORT];
        r_pv[i]   <= pv_in[i*WIDTH_PV +: WIDTH_PV];
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= r_flit[src(i)];
          wr_ptr[i]         <= ~wr_ptr[i];
        end
        if (pop[i])
          rd_ptr[i] <= ~rd_ptr[i];
        cnt[i] <= cnt[i] + 2'(push[i]) - 2'(pop[i]);
      end
    end
  end

`ifdef BYPASS_STAT_EN
  logic [15:0] cnt_drain [NUM_SUBNET];
  logic [15:0] cnt_sat   [NUM_SUBNET];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SUBNET; i++) begin
      if (reset) begin
        cnt_drain[i] <= '0;
        cnt_sat[i]   <= '0;
      end else begin
        if (push[i] && cnt_drain[i] != 16'hFFFF)
          cnt_drain[i] <= cnt_drain[i] + 16'd1;
        if (arr_max[i] && !push[i] && cnt_sat[i] != 16'hFFFF)
          cnt_sat[i] <= cnt_sat[i] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_drain = '0;
    stat_sat   = '0;
    for (int i = 0; i < NUM_SUBNET; i++) begin
      stat_drain[i*16 +: 16] = cnt_drain[i];
      stat_sat[i*16 +: 16]   = cnt_sat[i];
    end
  end
`else
  assign stat_drain = '0;
  assign stat_sat   = '0;
`endif

endmodule

// File: doc/dec_bypass_ring.md
# dec_bypass_ring

Parametrised inter-subnet bypass interconnect for the multi-subnet deflection router. It supports NUM_SUBNET subrouters; the current design is fixed at two subnets cross-wired combinationally. Each subrouter's bypass output is registered and delivered one cycle later to the next subnet in a ring. A hop count travels with every bypass flit. A flit that has circulated MAX_HOP times is pulled off the ring into a per-subnet drain FIFO, which feeds the local retransmit path.

## Interface
- NUM_SUBNET, 2, number of subrouters on the ring (≥2)
- WIDTH_PORT, `WIDTH_PORT, flit width
- WIDTH_PV, `WIDTH_PV, productive-vector width
- MAX_HOP, 3, ring traversals before drain (1..15)
- HOP_W, 4, hop-count width (must hold MAX_HOP)
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- byp_in  in  NUM_SUBNET*WIDTH_PORT  subnet i bypass flit, slice i
- pv_in  in  NUM_SUBNET*WIDTH_PV  subnet i bypass PV
- vld_in  in  NUM_SUBNET  subnet i bypass valid
- fwd_in  in  NUM_SUBNET  subnet i re-emits the bypass flit it received this cycle
- byp_out  out  NUM_SUBNET*WIDTH_PORT  flit presented to subnet i bypass input
- pv_out  out  NUM_SUBNET*WIDTH_PV  PV presented to subnet i
- vld_out  out  NUM_SUBNET  bypass valid to subnet i
- drain_flit  out  NUM_SUBNET*WIDTH_PORT  drain FIFO head, subnet i
- drain_vld  out  NUM_SUBNET  drain FIFO non-empty
- drain_rdy  in  NUM_SUBNET  consumer pops head when drain_vld&drain_rdy
- stat_drain  out  NUM_SUBNET*16  drained-flit counters (BYPASS_STAT_EN only)
- stat_sat  out  NUM_SUBNET*16  blocked-drain counters (BYPASS_STAT_EN only)

## Operation
- Ring stage register i holds {flit, pv, vld, hop}.
- The stage is loaded from subnet i's outputs and feeds subnet (i+1) mod NUM_SUBNET.
- Hop on load:
  - If fwd_in[i]=1, hop = hop of the stage feeding subnet i, plus 1, saturating at MAX_HOP.
  - Otherwise hop = 0.
  - If vld_in[i]=0, the stage loads vld=0, and hop and data are don't-care.
- Arrival check at subnet j (stage j−1 output):
  - If vld=1 and hop==MAX_HOP and drain FIFO j is not full, the flit is written to drain FIFO j. In that cycle vld_out[j]=0 and byp_out/pv_out[j] are zero.
  - If hop==MAX_HOP and the FIFO is full, the flit is presented normally to subnet j with vld_out[j]=1. It stays saturated at MAX_HOP and is retried at the next subnet.
- Drain FIFO per subnet:
  - Depth 2, two-pointer ring with a count.
  - Push and pop in the same cycle are allowed when full: the count is unchanged and no drop occurs.
  - Pop from empty is ignored.
- PV is not stored in the drain FIFO. The consumer recomputes it.
- Outputs byp_out, pv_out and vld_out are combinational from the ring register, gated only by the drain decision. The drain decision is combinational from hop and FIFO count.

## Timing
- Bypass latency is 1 cycle: vld_in[i] at edge N gives vld_out[(i+1) mod N] at N+1.
- Drain latency is 1 cycle: a flit drained at the edge where it arrives appears at drain_vld by the next cycle.
- Reset (synchronous, active-high) clears every ring stage vld and hop to 0, empties every FIFO, and zeroes counters. While reset is high and one cycle after, all of vld_out, drain_vld, byp_out, pv_out and drain_flit are 0.
- Reset mid-operation discards all in-flight ring and FIFO contents. There is no partial flush.
- In the same cycle, subnet i may accept the arriving bypass flit and emit a new one. Both happen; the register is overwritten.
- With NUM_SUBNET=2 the ring is the 0→1→0 cross-connection, now registered.

## Configuration
- BYPASS_STAT_EN defined:
  - stat_drain[i] increments on every FIFO push at subnet i.
  - stat_sat[i] increments on every cycle a MAX_HOP flit arrives at subnet i while its FIFO is full.
  - Counters are 16-bit, saturate at 0xFFFF, and reset to 0.
- BYPASS_STAT_EN undefined: no counter logic, and stat_drain and stat_sat are tied to 0.

## Test plan
- Pass-through:
  - Stimulus: NUM_SUBNET=4, vld_in[1]=1, flit 0xA5, fwd_in=0.
  - Response: vld_out[2]=1 with 0xA5 one cycle later; hop=0; no drain.
- Hop limit:
  - Stimulus: MAX_HOP=3; the flit is injected at subnet 0, then fwd_in is asserted at each receiving subnet.
  - Response: the flit is presented at subnets 1, 2 and 3, then drained at subnet 0 on the 4th arrival. vld_out[0]=0 that cycle and drain_vld[0]=1 next cycle.
- FIFO full:
  - Stimulus: drain_rdy[0]=0; three MAX_HOP flits arrive at subnet 0.
  - Response: the first two are drained; the third is presented with vld_out[0]=1, and with BYPASS_STAT_EN stat_sat[0]=1.
- Simultaneous:
  - Stimulus: the FIFO is full, and drain_rdy=1 in the same cycle a MAX_HOP flit arrives.
  - Response: pop and push both occur, the count stays at 2, and FIFO order is preserved.
- Reset mid-flight:
  - Stimulus: reset is asserted with all stages valid and FIFOs holding 2 entries.
  - Response: next cycle, all vld_out=0, drain_vld=0, and counters=0.
- Wrap/2-subnet:
  - Stimulus: NUM_SUBNET=2, both subnets inject at once.
  - Response: the flits swap subnets after 1 cycle.
